// File: rtl/mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult8_seq_ctrl
// Description : Sequential 8x8 unsigned multiplier controller. One external
//               HALF_W x HALF_W combinational multiplier is reused for the four
//               half-operand sub-products (LL, LH, HL, HH). The sub-products
//               are shifted and accumulated into a 4*HALF_W-bit result.
//               Operands and results use valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module mult8_seq_ctrl #(
    parameter int unsigned HALF_W    = 4,
    parameter bit          ZERO_SKIP = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2*HALF_W-1:0]   in_a_i,
    input  logic [2*HALF_W-1:0]   in_b_i,
    output logic [HALF_W-1:0]     mul_a_o,
    output logic [HALF_W-1:0]     mul_b_o,
    input  logic [2*HALF_W-1:0]   mul_p_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [4*HALF_W-1:0]   out_p_o,
    output logic                  busy_o
);

    localparam int unsigned c_OP_W = 2 * HALF_W;
    localparam int unsigned c_P_W  = 4 * HALF_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LL   = 3'd1,
        S_LH   = 3'd2,
        S_HL   = 3'd3,
        S_HH   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [c_OP_W-1:0]   a_q, a_d;
    logic [c_OP_W-1:0]   b_q, b_d;
    logic [c_P_W-1:0]    acc_q, acc_d;

    logic                w_operand_zero;
    logic [c_P_W-1:0]    w_p_ext;
    logic [HALF_W-1:0]   w_a_lo, w_a_hi, w_b_lo, w_b_hi;

    // A zero operand can only short-circuit the sequence when skipping is enabled.
    if (ZERO_SKIP) begin : g_zero_skip
        assign w_operand_zero = (in_a_i == '0) || (in_b_i == '0);
    end else begin : g_no_skip
        assign w_operand_zero = 1'b0;
    end

    // Core product zero-extended to accumulator width before any shift.
    assign w_p_ext = {{c_OP_W{1'b0}}, mul_p_i};

    assign w_a_lo = a_q[HALF_W-1:0];
    assign w_a_hi = a_q[c_OP_W-1:HALF_W];
    assign w_b_lo = b_q[HALF_W-1:0];
    assign w_b_hi = b_q[c_OP_W-1:HALF_W];

    // State, operand and accumulator registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    // Sequencing: each sub-product state steers the shared core and adds its weighted product.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mul_a_o = '0;
        mul_b_o = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_d     = in_a_i;
                    b_d     = in_b_i;
                    acc_d   = '0;
                    state_d = w_operand_zero ? S_DONE : S_LL;
                end
            end
            S_LL: begin
                mul_a_o = w_a_lo;
                mul_b_o = w_b_lo;
                acc_d   = acc_q + w_p_ext;
                state_d = S_LH;
            end
            S_LH: begin
                mul_a_o = w_a_lo;
                mul_b_o = w_b_hi;
                acc_d   = acc_q + (w_p_ext << HALF_W);
                state_d = S_HL;
            end
            S_HL: begin
                mul_a_o = w_a_hi;
                mul_b_o = w_b_lo;
                acc_d   = acc_q + (w_p_ext << HALF_W);
                state_d = S_HH;
            end
            S_HH: begin
                mul_a_o = w_a_hi;
                mul_b_o = w_b_hi;
                acc_d   = acc_q + (w_p_ext << (2 * HALF_W));
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decode directly from the state register.
    always_comb begin
        in_ready_o  = (state_q == S_IDLE);
        out_valid_o = (state_q == S_DONE);
        busy_o      = (state_q != S_IDLE);
        out_p_o     = (state_q == S_DONE) ? acc_q : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult8_seq_ctrl
// Description : Self-checking bench for mult8_seq_ctrl. A transaction-level
//               model predicts handshake/status/core-operand outputs every
//               cycle; directed scenarios pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [7:0]  in_a, in_b;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_p;
    logic        out_valid, out_ready;
    logic [15:0] out_p;
    logic        busy;

    // Second instance without zero skipping, shares operand buses.
    logic        in_valid0, in_ready0;
    logic [3:0]  mul_a0, mul_b0;
    logic [7:0]  mul_p0;
    logic        out_valid0, out_ready0;
    logic [15:0] out_p0;
    logic        busy0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // External 4x4 combinational cores.
    assign mul_p  = {4'b0, mul_a}  * {4'b0, mul_b};
    assign mul_p0 = {4'b0, mul_a0} * {4'b0, mul_b0};

    mult8_seq_ctrl #(.HALF_W(4), .ZERO_SKIP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b),
        .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_p_i(mul_p),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_p_o(out_p), .busy_o(busy)
    );

    mult8_seq_ctrl #(.HALF_W(4), .ZERO_SKIP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .in_a_i(in_a), .in_b_i(in_b),
        .mul_a_o(mul_a0), .mul_b_o(mul_b0), .mul_p_i(mul_p0),
        .out_valid_o(out_valid0), .out_ready_i(out_ready0),
        .out_p_o(out_p0), .busy_o(busy0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_step counts cycles since acceptance; result appears after m_lat cycles.
    logic        m_busy = 1'b0;
    int          m_step = 0;
    int          m_lat  = 5;
    logic [7:0]  m_a = '0, m_b = '0;
    logic [15:0] sb[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_step <= 0;
            sb.delete();
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_step <= 1;
                m_a    <= in_a;
                m_b    <= in_b;
                m_lat  <= (in_a == 8'd0 || in_b == 8'd0) ? 1 : 5;
                sb.push_back(16'(in_a) * 16'(in_b));
            end
        end else if (m_step < m_lat) begin
            m_step <= m_step + 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
            m_step <= 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic       e_valid;
        logic [3:0] e_ma, e_mb;
        logic [15:0] e_p;
        if ($time > 12) begin
            e_valid = m_busy && (m_step == m_lat);
            e_p     = e_valid ? (16'(m_a) * 16'(m_b)) : 16'h0;
            e_ma    = 4'h0;
            e_mb    = 4'h0;
            if (m_busy && m_lat == 5 && m_step >= 1 && m_step <= 4) begin
                e_ma = (m_step <= 2) ? m_a[3:0] : m_a[7:4];
                e_mb = (m_step == 1 || m_step == 3) ? m_b[3:0] : m_b[7:4];
            end
            chk("in_ready",  32'(in_ready),  32'(!m_busy));
            chk("busy",      32'(busy),      32'(m_busy));
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            chk("out_p",     32'(out_p),     32'(e_p));
            chk("mul_a",     32'(mul_a),     32'(e_ma));
            chk("mul_b",     32'(mul_b),     32'(e_mb));
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(out_p), 32'hFFFF_FFFF);
                end else begin
                    chk("scoreboard", 32'(out_p), 32'(sb[0]));
                    void'(sb.pop_front());
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic [7:0] subp [1:4];

    task automatic start(input logic [7:0] a, input logic [7:0] b);
        int n;
        in_a = a; in_b = b; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom);
    endtask

    // Called in cycle T+1; returns the cycle index at which out_valid rose.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            chk("busy_during_op", 32'(busy), 32'd1);
            if (lat <= 4) subp[lat] = mul_p;
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_at_done", 32'(busy), 32'd1);
    endtask

    logic rnd_done;

    initial begin
        int lat, lat0, k;
        rst_n = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1; out_ready0 = 1'b1; rnd_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_p",     32'(out_p),     32'd0);
        chk("rst_mul_ab",    32'({mul_a, mul_b}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: max operands
        start(8'hFF, 8'hFF);
        wait_valid(lat);
        chk("t1_latency", 32'(lat), 32'd5);
        chk("t1_out_p", 32'(out_p), 32'hFE01);
        @(posedge clk); #1;
        chk("t1_out_valid_drop", 32'(out_valid), 32'd0);
        chk("t1_idle", 32'(in_ready), 32'd1);

        // 2: sub-product sequence
        start(8'h12, 8'h34);
        wait_valid(lat);
        chk("t2_latency", 32'(lat), 32'd5);
        chk("t2_LL", 32'(subp[1]), 32'h08);
        chk("t2_LH", 32'(subp[2]), 32'h06);
        chk("t2_HL", 32'(subp[3]), 32'h04);
        chk("t2_HH", 32'(subp[4]), 32'h03);
        chk("t2_out_p", 32'(out_p), 32'h03A8);
        @(posedge clk); #1;

        // 3: zero operand, with and without skipping
        in_a = 8'h00; in_b = 8'hAB; in_valid = 1'b1; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid0 = 1'b0;
        lat = 0; lat0 = 0;
        for (k = 1; k <= 8; k++) begin
            if (k == 1) chk("t3_mul_zero", 32'({mul_a, mul_b}), 32'd0);
            if (out_valid && lat == 0) begin
                lat = k;
                chk("t3_out_p", 32'(out_p), 32'd0);
            end
            if (out_valid0 && lat0 == 0) begin
                lat0 = k;
                chk("t3_out_p_noskip", 32'(out_p0), 32'd0);
            end
            @(posedge clk); #1;
        end
        chk("t3_latency_skip", 32'(lat), 32'd1);
        chk("t3_latency_noskip", 32'(lat0), 32'd5);

        // 4: backpressure
        out_ready = 1'b0;
        start(8'hFF, 8'hFF);
        wait_valid(lat);
        chk("t4_latency", 32'(lat), 32'd5);
        repeat (3) begin
            @(posedge clk); #1;
            chk("t4_hold_p", 32'(out_p), 32'hFE01);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_release_valid", 32'(out_valid), 32'd0);
        chk("t4_release_idle", 32'(in_ready), 32'd1);

        // 5: reset during LH
        start(8'h55, 8'h66);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start(8'h0F, 8'h10);
        wait_valid(lat);
        chk("t5_latency", 32'(lat), 32'd5);
        chk("t5_out_p", 32'(out_p), 32'h00F0);
        @(posedge clk); #1;

        // 6: random traffic
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    logic [7:0] ra, rb;
                    ra = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                    rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    start(ra, rb);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        k = 0;
        while ((m_busy || sb.size() != 0) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_scoreboard", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
